seq_hit_counter_display: RTL and testbench

SEQ_HIT_COUNTER_DISPLAY -- requirements
Module: seq_hit_counter_display

---
 rtl/seq_hit_counter_display.sv | 137 +++++++++++++
 tb/tb_seq_hit_counter_display.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_hit_counter_display.sv
// seq_hit_counter_display
// Counts rising edges of an upstream detection flag, shows the count as a
// hex digit on a 7-segment display. The displayed digit can be frozen
// with hold while counting continues. seg[7] (dp) shows the sticky
// overflow flag.
// Optional feature macro: SEQ_HIT_STRETCH_EN -- when defined, dp is also
// lit for STRETCH_CYCLES cycles after every counted hit.
module seq_hit_counter_display #(
  parameter int unsigned STRETCH_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hit,
  input  logic       clear,
  input  logic       hold,
  output logic [7:0] seg,
  output logic [3:0] count,
  output logic       overflow
);

  // Hex digit to active-high segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic       hit_q;
  logic [3:0] count_q,    count_d;
  logic       overflow_q, overflow_d;
  logic [3:0] disp_q,     disp_d;
  logic [7:0] seg_q,      seg_d;
  logic       event_s;
  logic       dp_s;

  // A counted event is the first cycle of a high hit level
  assign event_s = hit & ~hit_q;

`ifdef SEQ_HIT_STRETCH_EN
  localparam logic [7:0] STRETCH_LOAD = 8'(STRETCH_CYCLES);

  logic [7:0] stretch_q, stretch_d;

  // Stretch counter: (re)load on every counted event, then run down to zero
  always_comb begin
    stretch_d = stretch_q;
    if (event_s) begin
      stretch_d = STRETCH_LOAD;
    end else if (stretch_q != 8'd0) begin
      stretch_d = stretch_q - 8'd1;
    end else begin
      stretch_d = 8'd0;
    end
  end

  // Stretch counter register; reset aborts a running stretch
  always_ff @(posedge clk) begin
    if (reset) begin
      stretch_q <= 8'd0;
    end else begin
      stretch_q <= stretch_d;
    end
  end

  assign dp_s = overflow_q | (stretch_q != 8'd0);
`else
  assign dp_s = overflow_q;
`endif

  // Next-state for counter, sticky overflow, display latch and segments
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    disp_d     = disp_q;
    seg_d      = {dp_s, hex_to_seg(disp_q)};
    if (clear) begin
      count_d    = 4'd0;
      overflow_d = 1'b0;
    end else if (event_s) begin
      count_d = count_q + 4'd1;
      if (count_q == 4'hF) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end else begin
      count_d    = count_q;
      overflow_d = overflow_q;
    end
    if (hold) begin
      disp_d = disp_q;
    end else begin
      disp_d = count_q;
    end
  end

  // State registers; hit_q keeps tracking hit through clear so a held
  // level is never recounted when clear drops
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q      <= 1'b0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
      disp_q     <= 4'd0;
      seg_q      <= 8'h3F;
    end else begin
      hit_q      <= hit;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      disp_q     <= disp_d;
      seg_q      <= seg_d;
    end
  end

  assign seg      = seg_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_hit_counter_display.sv
// Self-checking bench for seq_hit_counter_display: directed scenarios plus
// randomized stimulus, all compared against a cycle-level reference model.
// Builds with or without SEQ_HIT_STRETCH_EN.
module tb_seq_hit_counter_display;

  localparam int STRETCH = 8;

  logic       clk = 1'b0;
  logic       reset, hit, clear, hold;
  logic [7:0] seg;
  logic [3:0] count;
  logic       overflow;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int   m_count, m_disp, m_str;
  bit   m_ovf, m_hit_prev;
  logic [7:0] m_seg;
  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seq_hit_counter_display #(.STRETCH_CYCLES(STRETCH)) dut (
    .clk(clk), .reset(reset), .hit(hit), .clear(clear), .hold(hold),
    .seg(seg), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, act, exp);
  endtask

  // advance one clock edge, update the model from the inputs that edge saw
  task automatic step();
    bit ev, dp;
    @(posedge clk);
    if (reset) begin
      m_count = 0; m_ovf = 0; m_disp = 0; m_str = 0; m_hit_prev = 0;
      m_seg = 8'h3F;
    end else begin
      ev = hit && !m_hit_prev;
`ifdef SEQ_HIT_STRETCH_EN
      dp = m_ovf || (m_str > 0);
`else
      dp = m_ovf;
`endif
      m_seg = {dp, lut[m_disp]};
      if (!hold) m_disp = m_count;
      if (clear) begin
        m_count = 0; m_ovf = 0;
      end else if (ev) begin
        if (m_count == 15) m_ovf = 1;
        m_count = (m_count + 1) % 16;
      end
      if (ev) m_str = STRETCH;
      else if (m_str > 0) m_str = m_str - 1;
      m_hit_prev = hit;
    end
    #1;
    check("model_count", {4'h0, count}, 8'(m_count));
    check("model_ovf", {7'h0, overflow}, {7'h0, m_ovf});
    check("model_seg", seg, m_seg);
  endtask

  task automatic drive(input logic h, input logic c, input logic hd, input logic r);
    hit = h; clear = c; hold = hd; reset = r;
    step();
  endtask

  task automatic pulse_hits(input int n, input logic hd);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, hd, 1'b0);
      drive(1'b0, 1'b0, hd, 1'b0);
    end
  endtask

  initial begin
    m_count = 0; m_disp = 0; m_str = 0; m_ovf = 0; m_hit_prev = 0; m_seg = 8'h3F;
    hit = 1'b0; clear = 1'b0; hold = 1'b0; reset = 1'b1;

    // reset state
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_seg", seg, 8'h3F);
    check("rst_count", {4'h0, count}, 8'h00);
    check("rst_ovf", {7'h0, overflow}, 8'h00);

    // single hit: count next cycle, digit 1 three edges after sampling
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("hit1_count", {4'h0, count}, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("hit1_seg", {1'b0, seg[6:0]}, 8'h06);

    // held level counts once
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("level_once", {4'h0, count}, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("level_second", {4'h0, count}, 8'h02);

    // 16 hits wrap and set overflow
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    pulse_hits(16, 1'b0);
    check("wrap_count", {4'h0, count}, 8'h00);
    check("wrap_ovf", {7'h0, overflow}, 8'h01);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_seg", seg, 8'hBF);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("clr_ovf", {7'h0, overflow}, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("clr_seg", seg, 8'h3F);

    // hold freezes the digit while counting continues
    pulse_hits(5, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("hold_pre", {1'b0, seg[6:0]}, 8'h6D);
    pulse_hits(3, 1'b1);
    check("hold_count", {4'h0, count}, 8'h08);
    check("hold_seg", {1'b0, seg[6:0]}, 8'h6D);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("hold_rel1", {1'b0, seg[6:0]}, 8'h6D);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("hold_rel2", {1'b0, seg[6:0]}, 8'h7F);

    // clear with hold keeps the frozen digit
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("clrhold_count", {4'h0, count}, 8'h00);
    check("clrhold_seg", {1'b0, seg[6:0]}, 8'h7F);

    // clear beats a simultaneous rising hit
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    pulse_hits(3, 1'b0);
    check("pre_clr3", {4'h0, count}, 8'h03);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("clr_vs_hit", {4'h0, count}, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("clr_no_recount", {4'h0, count}, 8'h00);

    // hit already high when reset releases is counted
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst_hit", {4'h0, count}, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SEQ_HIT_STRETCH_EN
    // dp stretch lasts exactly STRETCH cycles; reset aborts it
    begin
      int lit;
      for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
      lit = 0;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        if (seg[7]) lit++;
      end
      check("stretch_len", 8'(lit), 8'(STRETCH));
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check("stretch_rst", seg, 8'h3F);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("stretch_abort", seg, 8'h3F);
    end
`endif

    // randomized stimulus against the model
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 30) == 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 150) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
